multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 138 +++++++++++++
 tb/tb_multicycle_control_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for a multicycle RISC-V datapath
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_UPPER    = 4'd11
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt        = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    case (cur)
      S_FETCH: begin
        // PC+4 is written back in the same cycle the instruction is latched
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        nxt        = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nxt = S_MEMADR;
          7'b0110011:             nxt = S_EXECR;
          7'b0010011:             nxt = S_EXECI;
          7'b1101111:             nxt = S_JAL;
          7'b1100011:             nxt = S_BEQ;
          7'b0110111, 7'b0010111: nxt = S_UPPER;
          default: begin
            nxt        = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt       = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        nxt       = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        nxt       = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        nxt       = S_FETCH;
      end
      S_UPPER: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        nxt       = S_ALUWB;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - bench for multicycle_control_fsm: directed and random instruction streams
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5,
                 EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BEQ = 10, UPPER = 11;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  logic [13:0] dut_out;
  assign dut_out = {pc_write, adr_src, mem_write, ir_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1101111, 7'b1100011, 7'b0110111, 7'b0010111};
  endfunction

  // Output table per state: {pw, adr, mw, irw, rw, rs, a, b, aop, ill}
  function automatic logic [13:0] exp_out(input int s, input logic mr, input logic z, input logic [6:0] o);
    logic pw, ad, mw, iw, rw, il;
    logic [1:0] rs, a, b, ao;
    {pw, ad, mw, iw, rw, il} = '0;
    {rs, a, b, ao} = '0;
    case (s)
      FETCH:    begin b = 2'b10; rs = 2'b10; iw = mr; pw = mr; end
      DECODE:   begin a = 2'b01; b = 2'b01; il = !is_legal(o); end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  ad = 1'b1;
      MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      MEMWRITE: begin ad = 1'b1; mw = 1'b1; end
      EXECR:    begin a = 2'b10; ao = 2'b10; end
      EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      ALUWB:    rw = 1'b1;
      JAL:      begin a = 2'b01; b = 2'b10; pw = 1'b1; end
      BEQ:      begin a = 2'b10; ao = 2'b01; pw = z; end
      UPPER:    begin a = 2'b01; b = 2'b01; ao = 2'b11; end
      default:  ;
    endcase
    return {pw, ad, mw, iw, rw, rs, a, b, ao, il};
  endfunction

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int es, input logic mr, input logic [6:0] o, input logic z);
    @(negedge clk);
    mem_ready = mr; op = o; zero = z;
    #1;
    chk("state", {10'd0, state}, 14'(es));
    chk("outputs", dut_out, exp_out(es, mr, z, o));
  endtask

  // Builds the expected cycle-by-cycle state path of one instruction and walks it
  task automatic run_instr(input logic [6:0] o, input logic z, input int wf, input int wm);
    int   sq[$];
    logic mq[$];
    for (int i = 0; i < wf; i++) begin sq.push_back(FETCH); mq.push_back(1'b0); end
    sq.push_back(FETCH); mq.push_back(1'b1);
    sq.push_back(DECODE); mq.push_back(1'($urandom));
    if (is_legal(o)) begin
      if (o == 7'b0000011 || o == 7'b0100011) begin
        sq.push_back(MEMADR); mq.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin
          sq.push_back(o[5] ? MEMWRITE : MEMREAD); mq.push_back(1'b0);
        end
        sq.push_back(o[5] ? MEMWRITE : MEMREAD); mq.push_back(1'b1);
        if (!o[5]) begin sq.push_back(MEMWB); mq.push_back(1'($urandom)); end
      end else if (o == 7'b1100011) begin
        sq.push_back(BEQ); mq.push_back(1'($urandom));
      end else begin
        case (o)
          7'b0110011: sq.push_back(EXECR);
          7'b0010011: sq.push_back(EXECI);
          7'b1101111: sq.push_back(JAL);
          default:    sq.push_back(UPPER);
        endcase
        mq.push_back(1'($urandom));
        sq.push_back(ALUWB); mq.push_back(1'($urandom));
      end
    end
    for (int i = 0; i < sq.size(); i++) step(sq[i], mq[i], o, z);
  endtask

  logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1101111, 7'b1100011, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] rop;
    reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset_mr0", {10'd0, state} ^ dut_out, 14'(FETCH) ^ exp_out(FETCH, 1'b0, 1'b0, 7'd0));
    chk("reset_out_mr0", dut_out, exp_out(FETCH, 1'b0, 1'b0, 7'd0));
    mem_ready = 1'b1; #1;
    chk("reset_out_mr1", dut_out, exp_out(FETCH, 1'b1, 1'b0, 7'd0));
    chk("reset_state", {10'd0, state}, 14'(FETCH));
    @(negedge clk); mem_ready = 1'b0; reset = 1'b0;

    run_instr(7'b0000011, 1'b0, 0, 0);   // lw
    run_instr(7'b0100011, 1'b0, 0, 2);   // sw, two wait cycles
    run_instr(7'b1100011, 1'b1, 0, 0);   // beq taken
    run_instr(7'b1100011, 1'b0, 0, 0);   // beq not taken
    run_instr(7'b1111111, 1'b0, 0, 0);   // illegal
    run_instr(7'b0110111, 1'b0, 0, 0);   // lui
    run_instr(7'b1101111, 1'b0, 2, 0);   // jal with fetch wait

    // Reset in the middle of a stalled load
    step(FETCH, 1'b1, 7'b0000011, 1'b0);
    step(DECODE, 1'b0, 7'b0000011, 1'b0);
    step(MEMADR, 1'b0, 7'b0000011, 1'b0);
    step(MEMREAD, 1'b0, 7'b0000011, 1'b0);
    #2 reset = 1'b1; #1;
    chk("async_reset_state", {10'd0, state}, 14'(FETCH));
    chk("async_reset_out", dut_out, exp_out(FETCH, 1'b0, 1'b0, 7'b0000011));
    mem_ready = 1'b1; #1;
    chk("in_reset_mr1", dut_out, exp_out(FETCH, 1'b1, 1'b0, 7'b0000011));
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    chk("post_reset_state", {10'd0, state}, 14'(FETCH));
    chk("post_reset_out", dut_out, exp_out(FETCH, 1'b0, 1'b0, 7'b0000011));

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 7'($urandom); while (is_legal(rop));
      end else begin
        rop = legal_ops[$urandom_range(0, 7)];
      end
      run_instr(rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    step(FETCH, 1'b0, 7'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
